// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: operand/tag widths, LSQ entry payload and CDB broadcast.
package tomasulo_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned LSQ_DEPTH = 4;

  typedef struct packed {
    logic             valid;
    logic             ls;        // 1=store
    logic [XLEN-1:0]  rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_rdy;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] rd_tag;
  } lsq_entry_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } cdb_t;

  // True when a CDB broadcast supplies an operand that is still waiting on it.
  function automatic logic cdb_hit(input cdb_t cdb, input logic rdy,
                                   input logic [TAG_W-1:0] tag);
    return cdb.valid && !rdy && (cdb.tag == tag);
  endfunction

endpackage

// File: rtl/ls_queue_entry.sv
// One load/store queue slot: holds the op, snoops the CDB for missing operands,
// and presents its effective address / store data to the issue mux.
module ls_queue_entry
  import tomasulo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  lsq_entry_t       wr_entry,
  input  logic             clr,
  input  cdb_t             cdb,
  output logic             valid,
  output logic             ls,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rdy_c,
  output logic [XLEN-1:0]  addr_c,
  output logic [XLEN-1:0]  st_data_c
);

  lsq_entry_t q, d;

  // Next entry state: write (with dispatch-cycle bypass), else wakeup; clear on issue/flush.
  always_comb begin
    d = q;
    if (wr_en) begin
      d = wr_entry;
      if (cdb_hit(cdb, wr_entry.rs1_rdy, wr_entry.rs1_tag)) begin
        d.rs1_data = cdb.data;
        d.rs1_rdy  = 1'b1;
      end
      if (cdb_hit(cdb, wr_entry.rs2_rdy, wr_entry.rs2_tag)) begin
        d.rs2_data = cdb.data;
        d.rs2_rdy  = 1'b1;
      end
    end else if (q.valid) begin
      if (cdb_hit(cdb, q.rs1_rdy, q.rs1_tag)) begin
        d.rs1_data = cdb.data;
        d.rs1_rdy  = 1'b1;
      end
      if (cdb_hit(cdb, q.rs2_rdy, q.rs2_tag)) begin
        d.rs2_data = cdb.data;
        d.rs2_rdy  = 1'b1;
      end
    end
    if (clr || flush) d.valid = 1'b0;
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign valid     = q.valid;
  assign ls        = q.ls;
  assign rd_tag    = q.rd_tag;
  // Operands complete: loads need only the base, stores also need the data.
  assign rdy_c     = q.rs1_rdy && (!q.ls || q.rs2_rdy);
  assign addr_c    = q.rs1_data + q.imm;
  assign st_data_c = q.ls ? q.rs2_data : '0;

endmodule

// File: rtl/ls_issue_queue.sv
// In-order load/store reservation queue feeding agu_unit.
// Optional macro LSQ_PERF_CNT_EN adds perf_issued / perf_head_stall counters.
module ls_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH = LSQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_en,
  input  logic             disp_ls,
  input  logic [XLEN-1:0]  disp_rs1_data,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic             disp_rs1_rdy,
  input  logic [XLEN-1:0]  disp_rs2_data,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             disp_rs2_rdy,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [TAG_W-1:0] disp_rd_tag,
  output logic             queue_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  input  logic             agu_ready,
  output logic             agu_issue,
  output logic [XLEN-1:0]  agu_addr,
  output logic [XLEN-1:0]  agu_data,
  output logic             agu_ls,
  output logic [TAG_W-1:0] agu_tag,
  output logic             agu_tag_valid
`ifdef LSQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_head_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head, head_d, tail, tail_d;
  logic [CNT_W-1:0] count, count_d;
  logic             do_disp, do_issue;
  lsq_entry_t       wr_entry;
  cdb_t             cdb;

  logic             ent_valid   [DEPTH];
  logic             ent_ls      [DEPTH];
  logic [TAG_W-1:0] ent_rd_tag  [DEPTH];
  logic             ent_rdy     [DEPTH];
  logic [XLEN-1:0]  ent_addr    [DEPTH];
  logic [XLEN-1:0]  ent_st_data [DEPTH];

  assign cdb = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};

  assign wr_entry = '{valid: 1'b1, ls: disp_ls,
                      rs1_data: disp_rs1_data, rs1_tag: disp_rs1_tag, rs1_rdy: disp_rs1_rdy,
                      rs2_data: disp_rs2_data, rs2_tag: disp_rs2_tag, rs2_rdy: disp_rs2_rdy,
                      imm: disp_imm, rd_tag: disp_rd_tag};

  // Full blocks dispatch only; issue is strictly from the head.
  assign do_disp  = !flush && disp_en && !queue_full;
  assign do_issue = !flush && agu_ready && ent_valid[head] && ent_rdy[head];

  // Queue slots.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    ls_queue_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .wr_en     (do_disp && (tail == PTR_W'(i))),
      .wr_entry  (wr_entry),
      .clr       (do_issue && (head == PTR_W'(i))),
      .cdb       (cdb),
      .valid     (ent_valid[i]),
      .ls        (ent_ls[i]),
      .rd_tag    (ent_rd_tag[i]),
      .rdy_c     (ent_rdy[i]),
      .addr_c    (ent_addr[i]),
      .st_data_c (ent_st_data[i])
    );
  end

  // Pointer and occupancy update; flush empties the queue.
  always_comb begin
    head_d  = head;
    tail_d  = tail;
    count_d = count;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_disp)  tail_d = tail + PTR_W'(1);
      if (do_issue) head_d = head + PTR_W'(1);
      if (do_disp && !do_issue)      count_d = count + CNT_W'(1);
      else if (!do_disp && do_issue) count_d = count - CNT_W'(1);
    end
  end

  // Pointer, count and full-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      queue_full <= 1'b0;
    end else begin
      head       <= head_d;
      tail       <= tail_d;
      count      <= count_d;
      queue_full <= (count_d == CNT_W'(DEPTH));
    end
  end

  // AGU output registers: loaded on issue, otherwise held (tag_valid dropped on flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agu_issue     <= 1'b0;
      agu_addr      <= '0;
      agu_data      <= '0;
      agu_ls        <= 1'b0;
      agu_tag       <= '0;
      agu_tag_valid <= 1'b0;
    end else begin
      agu_issue <= do_issue;
      if (do_issue) begin
        agu_addr      <= ent_addr[head];
        agu_data      <= ent_st_data[head];
        agu_ls        <= ent_ls[head];
        agu_tag       <= ent_rd_tag[head];
        agu_tag_valid <= !ent_ls[head];
      end else if (flush) begin
        agu_tag_valid <= 1'b0;
      end
    end
  end

`ifdef LSQ_PERF_CNT_EN
  // Performance counters, cleared by reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued     <= '0;
      perf_head_stall <= '0;
    end else begin
      if (do_issue)                     perf_issued     <= perf_issued + 32'd1;
      if (ent_valid[head] && !do_issue) perf_head_stall <= perf_head_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed self-checking bench for ls_issue_queue.
module tb_ls_issue_queue;
  import tomasulo_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             disp_en, disp_ls, disp_rs1_rdy, disp_rs2_rdy;
  logic [XLEN-1:0]  disp_rs1_data, disp_rs2_data, disp_imm;
  logic [TAG_W-1:0] disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
  logic             queue_full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             agu_ready;
  logic             agu_issue, agu_ls, agu_tag_valid;
  logic [XLEN-1:0]  agu_addr, agu_data;
  logic [TAG_W-1:0] agu_tag;
`ifdef LSQ_PERF_CNT_EN
  logic [31:0]      perf_issued, perf_head_stall;
`endif

  int checks   = 0;
  int failures = 0;
  logic [72:0] obs;

  ls_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_en(disp_en), .disp_ls(disp_ls),
    .disp_rs1_data(disp_rs1_data), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2_data(disp_rs2_data), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_imm(disp_imm), .disp_rd_tag(disp_rd_tag), .queue_full(queue_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .agu_ready(agu_ready), .agu_issue(agu_issue), .agu_addr(agu_addr),
    .agu_data(agu_data), .agu_ls(agu_ls), .agu_tag(agu_tag), .agu_tag_valid(agu_tag_valid)
`ifdef LSQ_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_head_stall(perf_head_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // {issue, ls, tag_valid, tag, addr, data}
  function automatic logic [72:0] obs_vec();
    return {agu_issue, agu_ls, agu_tag_valid, agu_tag, agu_addr, agu_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; disp_en = 0; disp_ls = 0;
    disp_rs1_data = '0; disp_rs1_tag = '0; disp_rs1_rdy = 0;
    disp_rs2_data = '0; disp_rs2_tag = '0; disp_rs2_rdy = 0;
    disp_imm = '0; disp_rd_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic disp_set(input logic ls, input logic [31:0] rs1, input logic [5:0] t1,
                          input logic r1, input logic [31:0] rs2, input logic [5:0] t2,
                          input logic r2, input logic [31:0] imm, input logic [5:0] rd);
    disp_en = 1; disp_ls = ls;
    disp_rs1_data = rs1; disp_rs1_tag = t1; disp_rs1_rdy = r1;
    disp_rs2_data = rs2; disp_rs2_tag = t2; disp_rs2_rdy = r2;
    disp_imm = imm; disp_rd_tag = rd;
  endtask

  task automatic test_reset();
    idle_inputs(); agu_ready = 0; rst_n = 0;
    step(); step();
    obs = obs_vec();
    checks++; if (obs !== 73'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", queue_full); end
    rst_n = 1; step();
  endtask

  task automatic test_load();
    agu_ready = 1;
    disp_set(0, 32'h1000, 6'd0, 1, 32'h0, 6'd0, 1, 32'h10, 6'd7);
    step(); disp_en = 0;
    obs = obs_vec();
    checks++; if (obs !== 73'h0) begin failures++; $display("FAIL load_disp_cycle got=%h exp=0", obs); end
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd7, 32'h1010, 32'h0}) begin failures++; $display("FAIL load_issue got=%h", obs); end
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b0, 1'b0, 1'b1, 6'd7, 32'h1010, 32'h0}) begin failures++; $display("FAIL load_hold got=%h", obs); end
  endtask

  task automatic test_store_wakeup();
    disp_set(1, 32'h2000, 6'd0, 1, 32'h0, 6'd5, 0, 32'h4, 6'd9);
    step(); disp_en = 0;
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL store_wait got=%b exp=0", agu_issue); end
    cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'hDEAD;
    step(); cdb_valid = 0;
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL store_wake_cycle got=%b exp=0", agu_issue); end
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b1, 1'b0, 6'd9, 32'h2004, 32'hDEAD}) begin failures++; $display("FAIL store_issue got=%h", obs); end
    step();
  endtask

  task automatic test_in_order();
    disp_set(0, 32'h0, 6'd3, 0, 32'h0, 6'd0, 1, 32'h8, 6'd10);
    step();
    disp_set(0, 32'h300, 6'd0, 1, 32'h0, 6'd0, 1, 32'h0, 6'd11);
    step(); disp_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL inorder_stall%0d got=%b exp=0", i, agu_issue); end
    end
    cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 32'h100;
    step(); cdb_valid = 0;
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd10, 32'h108, 32'h0}) begin failures++; $display("FAIL inorder_first got=%h", obs); end
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd11, 32'h300, 32'h0}) begin failures++; $display("FAIL inorder_second got=%h", obs); end
    step();
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL inorder_drain got=%b exp=0", agu_issue); end
  endtask

  task automatic test_full();
    logic [31:0] exp_addr [5];
    logic [5:0]  exp_tag  [5];
    exp_addr = '{32'h4, 32'h44, 32'h84, 32'hC4, 32'h504};
    exp_tag  = '{6'd20, 6'd21, 6'd22, 6'd23, 6'd25};
    agu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      disp_set(0, 32'h40 * i, 6'd0, 1, 32'h0, 6'd0, 1, 32'h4, 6'(20 + i));
      step();
    end
    checks++; if (queue_full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", queue_full); end
    disp_set(0, 32'h999, 6'd0, 1, 32'h0, 6'd0, 1, 32'h4, 6'd24);
    step();
    checks++; if ({queue_full, agu_issue} !== 2'b10) begin failures++; $display("FAIL full_drop got=%b exp=10", {queue_full, agu_issue}); end
    agu_ready = 1;
    disp_set(0, 32'h500, 6'd0, 1, 32'h0, 6'd0, 1, 32'h4, 6'd25);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) disp_en = 0;
      obs = obs_vec();
      checks++; if (obs !== {1'b1, 1'b0, 1'b1, exp_tag[i], exp_addr[i], 32'h0}) begin failures++; $display("FAIL full_drain%0d got=%h", i, obs); end
      checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL full_clear%0d got=%b exp=0", i, queue_full); end
    end
    step();
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", agu_issue); end
  endtask

  task automatic test_bypass();
    disp_set(0, 32'h0, 6'd12, 0, 32'h0, 6'd0, 1, 32'h1, 6'd30);
    cdb_valid = 1; cdb_tag = 6'd12; cdb_data = 32'h7000;
    step(); disp_en = 0; cdb_valid = 0;
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL bypass_disp_cycle got=%b exp=0", agu_issue); end
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd30, 32'h7001, 32'h0}) begin failures++; $display("FAIL bypass_issue got=%h", obs); end
    step();
    disp_set(1, 32'h0, 6'd40, 0, 32'h0, 6'd40, 0, 32'h8, 6'd31);
    step(); disp_en = 0;
    cdb_valid = 1; cdb_tag = 6'd40; cdb_data = 32'h50;
    step(); cdb_valid = 0;
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL dualwake_cycle got=%b exp=0", agu_issue); end
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b1, 1'b0, 6'd31, 32'h58, 32'h50}) begin failures++; $display("FAIL dualwake_issue got=%h", obs); end
    step();
  endtask

  task automatic test_wrap();
    disp_set(0, 32'hFFFF_FFF0, 6'd0, 1, 32'h0, 6'd0, 1, 32'h20, 6'd33);
    step(); disp_en = 0;
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd33, 32'h10, 32'h0}) begin failures++; $display("FAIL addr_wrap got=%h", obs); end
    step();
  endtask

  task automatic test_flush();
    agu_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp_set(0, 32'h100 * (i + 1), 6'd0, 1, 32'h0, 6'd0, 1, 32'h0, 6'(40 + i));
      step();
    end
    disp_en = 0; flush = 1; agu_ready = 1;
    step(); flush = 0;
    checks++; if ({agu_issue, agu_tag_valid, queue_full} !== 3'b000) begin failures++; $display("FAIL flush_outputs got=%b exp=000", {agu_issue, agu_tag_valid, queue_full}); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL flush_empty%0d got=%b exp=0", i, agu_issue); end
    end
    disp_set(0, 32'hA0, 6'd0, 1, 32'h0, 6'd0, 1, 32'h0, 6'd43);
    step(); disp_en = 0;
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd43, 32'hA0, 32'h0}) begin failures++; $display("FAIL flush_reuse got=%h", obs); end
    step();
  endtask

  task automatic test_async_reset();
    agu_ready = 0;
    disp_set(0, 32'h10, 6'd0, 1, 32'h0, 6'd0, 1, 32'h0, 6'd44); step();
    disp_set(0, 32'h20, 6'd0, 1, 32'h0, 6'd0, 1, 32'h0, 6'd45); step();
    disp_en = 0; agu_ready = 1;
    step(); obs = obs_vec();
    checks++; if (obs !== {1'b1, 1'b0, 1'b1, 6'd44, 32'h10, 32'h0}) begin failures++; $display("FAIL prereset_issue got=%h", obs); end
    #1 rst_n = 0;
    #1 obs = obs_vec();
    checks++; if ({obs, queue_full} !== 74'h0) begin failures++; $display("FAIL async_reset got=%h full=%b", obs, queue_full); end
    #1 rst_n = 1;
    step(); step();
    checks++; if (agu_issue !== 1'b0) begin failures++; $display("FAIL postreset_idle got=%b exp=0", agu_issue); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wakeup();
    test_in_order();
    test_full();
    test_bypass();
    test_wrap();
    test_flush();
`ifdef LSQ_PERF_CNT_EN
    checks++; if (perf_issued !== 32'd13) begin failures++; $display("FAIL perf_issued got=%0d exp=13", perf_issued); end
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
